// File: rtl/stage_mem_sram_ctrl_pkg.sv
// Shared types and constants for the memory-stage SRAM controller.
package stage_mem_sram_ctrl_pkg;

  // Controller FSM: idle, low half-word access, high half-word access, release.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  // Half-word select bit appended to the SRAM word address.
  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

  // Byte address that maps onto SRAM word 0.
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

  // Offset of a byte address from the SRAM window base, wrapping modulo 2^32.
  function automatic logic [31:0] byte_offset(input logic [31:0] addr,
                                              input logic [31:0] base);
    return addr - base;
  endfunction

endpackage

// File: rtl/stage_mem_sram_ctrl_sram_wait_counter.sv
// Wait-state counter for one half-word SRAM access. expired flags the last
// cycle of the access (count == WAIT_CYCLES-1); clear has priority over enable.
module sram_wait_counter #(
  parameter int WAIT_CYCLES = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [3:0] LAST_COUNT = 4'(WAIT_CYCLES - 1);

  logic [3:0] count_r;

  // Count wait cycles of the current half-word access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= 4'd0;
    end else if (clr) begin
      count_r <= 4'd0;
    end else if (en) begin
      count_r <= count_r + 4'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == LAST_COUNT);

endmodule

// File: rtl/stage_mem_sram_ctrl.sv
// Memory-stage SRAM controller: splits each 32-bit load/store into two
// half-word accesses on a 16-bit SRAM with programmable wait states, and
// holds ready low to freeze the pipeline while an access is in flight.
// Optional build macro MEM_STAGE_RANGE_CHECK_EN adds the err port and rejects
// requests outside the SRAM window; without it, offsets wrap by truncation.
module stage_mem_sram_ctrl
  import stage_mem_sram_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          WAIT_CYCLES = 5,
  parameter int          SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               memREn,
  input  logic               memWEn,
  input  logic [31:0]        address,
  input  logic [31:0]        writeData,
  output logic [31:0]        readData,
  output logic               ready,
  output logic [SRAM_AW-1:0] sramAddr,
  output logic [15:0]        sramDqOut,
  input  logic [15:0]        sramDqIn,
  output logic               sramDqOe,
  output logic               sramWeN
`ifdef MEM_STAGE_RANGE_CHECK_EN
  ,
  output logic               err
`endif
);

  state_t             state_r;
  state_t             state_next_s;
  logic [31:0]        addr_r;
  logic [31:0]        wdata_r;
  logic               is_write_r;

  logic               in_idle_s;
  logic               req_s;
  logic               start_s;
  logic [31:0]        sel_addr_s;
  logic [31:0]        sel_wdata_s;
  logic               sel_write_s;
  logic [31:0]        offs_s;
  logic [SRAM_AW-2:0] word_s;
  logic               out_of_range_s;
  logic               range_load_s;
  logic               cnt_clr_s;
  logic               cnt_en_s;
  logic               expired_s;
  logic               unused_bits_s;

  assign in_idle_s = (state_r == IDLE);
  assign req_s     = memREn | memWEn;

  // In IDLE the live request is used so the first SRAM cycle lines up with
  // the LO state; afterwards only the latched copy matters.
  assign sel_addr_s  = in_idle_s ? address   : addr_r;
  assign sel_wdata_s = in_idle_s ? writeData : wdata_r;
  assign sel_write_s = in_idle_s ? memWEn    : is_write_r;

  assign offs_s = byte_offset(sel_addr_s, BASE_ADDR);
  assign word_s = offs_s[SRAM_AW:2];

`ifdef MEM_STAGE_RANGE_CHECK_EN
  assign out_of_range_s = |offs_s[31:SRAM_AW+1];
  assign err            = in_idle_s & req_s & out_of_range_s;
`else
  assign out_of_range_s = 1'b0;
`endif

  assign range_load_s  = in_idle_s & memREn & ~memWEn & out_of_range_s;
  assign start_s       = in_idle_s & (state_next_s == LO);
  assign unused_bits_s = ^{offs_s[31:SRAM_AW+1], offs_s[1:0]};

  sram_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait_counter (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr_s),
    .en     (cnt_en_s),
    .expired(expired_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state, ready and wait-counter control.
  always_comb begin
    state_next_s = state_r;
    ready        = 1'b0;
    cnt_clr_s    = 1'b0;
    cnt_en_s     = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_clr_s = 1'b1;
        if (req_s && !out_of_range_s) begin
          ready        = 1'b0;
          state_next_s = LO;
        end else begin
          ready        = 1'b1;
          state_next_s = IDLE;
        end
      end
      LO: begin
        cnt_en_s = 1'b1;
        if (expired_s) begin
          cnt_clr_s    = 1'b1;
          state_next_s = HI;
        end else begin
          state_next_s = LO;
        end
      end
      HI: begin
        cnt_en_s = 1'b1;
        if (expired_s) begin
          cnt_clr_s    = 1'b1;
          state_next_s = DONE;
        end else begin
          state_next_s = HI;
        end
      end
      DONE: begin
        ready        = 1'b1;
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Latch the request when an access starts so later input changes are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_r     <= 32'd0;
      wdata_r    <= 32'd0;
      is_write_r <= 1'b0;
    end else if (start_s) begin
      addr_r     <= address;
      wdata_r    <= writeData;
      is_write_r <= memWEn;
    end else begin
      addr_r     <= addr_r;
      wdata_r    <= wdata_r;
      is_write_r <= is_write_r;
    end
  end

  // SRAM pins registered from the next state so they align with LO/HI.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sramAddr  <= '0;
      sramDqOut <= 16'd0;
      sramDqOe  <= 1'b0;
      sramWeN   <= 1'b1;
    end else begin
      case (state_next_s)
        LO: begin
          sramAddr <= {word_s, HALF_LO};
          sramDqOe <= sel_write_s;
          sramWeN  <= ~sel_write_s;
          if (sel_write_s) begin
            sramDqOut <= sel_wdata_s[15:0];
          end else begin
            sramDqOut <= sramDqOut;
          end
        end
        HI: begin
          sramAddr <= {word_s, HALF_HI};
          sramDqOe <= sel_write_s;
          sramWeN  <= ~sel_write_s;
          if (sel_write_s) begin
            sramDqOut <= sel_wdata_s[31:16];
          end else begin
            sramDqOut <= sramDqOut;
          end
        end
        default: begin
          sramAddr  <= sramAddr;
          sramDqOut <= sramDqOut;
          sramDqOe  <= 1'b0;
          sramWeN   <= 1'b1;
        end
      endcase
    end
  end

  // Load data: capture each half on the last wait cycle of a read; otherwise hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      readData <= 32'd0;
    end else if ((state_r == LO) && expired_s && !is_write_r) begin
      readData[15:0] <= sramDqIn;
    end else if ((state_r == HI) && expired_s && !is_write_r) begin
      readData[31:16] <= sramDqIn;
    end else if (range_load_s) begin
      readData <= 32'd0;
    end else begin
      readData <= readData;
    end
  end

endmodule

// File: tb/tb_stage_mem_sram_ctrl.sv
// Directed bench: a W=5 instance for the table and corner cases, and a W=1
// instance for back-to-back accesses. Both share request inputs and each has
// its own 16-bit SRAM model.
module tb_stage_mem_sram_ctrl;

  logic        clk;
  logic        rst;
  logic        memREn;
  logic        memWEn;
  logic [31:0] address;
  logic [31:0] writeData;

  logic [31:0] readData5, readData1;
  logic        ready5, ready1;
  logic [17:0] sramAddr5, sramAddr1;
  logic [15:0] sramDqOut5, sramDqOut1;
  logic [15:0] sramDqIn5, sramDqIn1;
  logic        sramDqOe5, sramDqOe1;
  logic        sramWeN5, sramWeN1;
`ifdef MEM_STAGE_RANGE_CHECK_EN
  logic        err5, err1;
`endif

  logic        pre_en;
  logic [17:0] pre_addr;
  logic [15:0] pre_data;
  logic [15:0] mem5 [0:262143];
  logic [15:0] mem1 [0:262143];

  logic [17:0] addr_log [0:63];
  logic [15:0] dq_log   [0:63];
  logic        we_log   [0:63];

  int pass_cnt;
  int total_cnt;

  stage_mem_sram_ctrl #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(5), .SRAM_AW(18)) dut5 (
    .clk(clk), .rst(rst), .memREn(memREn), .memWEn(memWEn),
    .address(address), .writeData(writeData), .readData(readData5),
    .ready(ready5), .sramAddr(sramAddr5), .sramDqOut(sramDqOut5),
    .sramDqIn(sramDqIn5), .sramDqOe(sramDqOe5), .sramWeN(sramWeN5)
`ifdef MEM_STAGE_RANGE_CHECK_EN
    , .err(err5)
`endif
  );

  stage_mem_sram_ctrl #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(1), .SRAM_AW(18)) dut1 (
    .clk(clk), .rst(rst), .memREn(memREn), .memWEn(memWEn),
    .address(address), .writeData(writeData), .readData(readData1),
    .ready(ready1), .sramAddr(sramAddr1), .sramDqOut(sramDqOut1),
    .sramDqIn(sramDqIn1), .sramDqOe(sramDqOe1), .sramWeN(sramWeN1)
`ifdef MEM_STAGE_RANGE_CHECK_EN
    , .err(err1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM models: bench preload port, otherwise written by the active-low strobe.
  always @(posedge clk) begin
    if (pre_en) begin
      mem5[pre_addr] <= pre_data;
      mem1[pre_addr] <= pre_data;
    end else begin
      if (!sramWeN5) mem5[sramAddr5] <= sramDqOut5;
      if (!sramWeN1) mem1[sramAddr1] <= sramDqOut1;
    end
  end

  assign sramDqIn5 = mem5[sramAddr5];
  assign sramDqIn1 = mem1[sramAddr1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Present one request and follow the chosen instance until ready returns.
  // Ends sampling the DONE cycle; log index k is the sample after the k-th edge.
  task automatic run(input logic sel, input logic re, input logic we,
                     input logic [31:0] a, input logic [31:0] d,
                     output int low, output int we_low);
    bit   done;
    logic rdy;
    logic wen;
    memREn = re; memWEn = we; address = a; writeData = d;
    low = 0; we_low = 0; done = 1'b0;
    #1;
    for (int k = 0; k < 64; k++) begin
      if (!done) begin
        rdy = sel ? ready1 : ready5;
        wen = sel ? sramWeN1 : sramWeN5;
        addr_log[k] = sel ? sramAddr1 : sramAddr5;
        dq_log[k]   = sel ? sramDqOut1 : sramDqOut5;
        we_log[k]   = wen;
        if (!wen) we_low++;
        if (rdy) begin
          done = 1'b1;
        end else begin
          low++;
          @(posedge clk); #1;
          if (k == 0) begin memREn = 1'b0; memWEn = 1'b0; end
        end
      end
    end
    check("access_terminates", {31'd0, done}, 32'd1);
  endtask

  typedef struct {
    logic        re;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [17:0] exp_lo;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int low;
    int we_low;
    pass_cnt = 0; total_cnt = 0;
    rst = 1'b0; memREn = 1'b0; memWEn = 1'b0; address = 32'd0; writeData = 32'd0;
    pre_en = 1'b0; pre_addr = 18'd0; pre_data = 16'd0;

    vecs[0] = '{1'b1, 1'b0, 32'd1032,     32'h0,        18'd4,       32'h12345678};
    vecs[1] = '{1'b1, 1'b1, 32'd1028,     32'hA5A55A5A, 18'd2,       32'h12345678};
    vecs[2] = '{1'b1, 1'b0, 32'd1028,     32'h0,        18'd2,       32'hA5A55A5A};
    vecs[3] = '{1'b1, 1'b0, 32'd1027,     32'h0,        18'd0,       32'hDEADBEEF};
    vecs[4] = '{1'b0, 1'b1, 32'h000403F8, 32'h0BADF00D, 18'h1FFFC,   32'hDEADBEEF};
    vecs[5] = '{1'b1, 1'b0, 32'h000403F8, 32'h0,        18'h1FFFC,   32'h0BADF00D};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready",    {31'd0, ready5},    32'd1);
    check("rst_readData", readData5,          32'd0);
    check("rst_sramWeN",  {31'd0, sramWeN5},  32'd1);
    check("rst_sramDqOe", {31'd0, sramDqOe5}, 32'd0);
    check("rst_sramAddr", {14'd0, sramAddr5}, 32'd0);

    @(negedge clk) rst = 1'b1;
    pre_en = 1'b1; pre_addr = 18'd4; pre_data = 16'h5678;
    @(negedge clk) pre_addr = 18'd5; pre_data = 16'h1234;
    @(negedge clk) pre_en = 1'b0;
    @(posedge clk); #1;

    // Store 0xDEADBEEF to the window base, cycle by cycle.
    run(1'b0, 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, low, we_low);
    check("st_low_cycles", low, 32'd11);
    check("st_req_weN",    {31'd0, we_log[0]}, 32'd1);
    check("st_c1_addr",    {14'd0, addr_log[1]}, 32'd0);
    check("st_c1_dq",      {16'd0, dq_log[1]}, 32'h0000BEEF);
    check("st_c1_weN",     {31'd0, we_log[1]}, 32'd0);
    check("st_c5_addr",    {14'd0, addr_log[5]}, 32'd0);
    check("st_c6_addr",    {14'd0, addr_log[6]}, 32'd1);
    check("st_c6_dq",      {16'd0, dq_log[6]}, 32'h0000DEAD);
    check("st_c10_weN",    {31'd0, we_log[10]}, 32'd0);
    check("st_done_weN",   {31'd0, we_log[11]}, 32'd1);
    check("st_we_cycles",  we_low, 32'd10);
    check("st_readData",   readData5, 32'd0);

    // Table of loads/stores on the W=5 instance.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      run(1'b0, vecs[i].re, vecs[i].we, vecs[i].addr, vecs[i].wdata, low, we_low);
      check($sformatf("v%0d_low", i), low, 32'd11);
      check($sformatf("v%0d_lo_addr", i), {14'd0, addr_log[1]}, {14'd0, vecs[i].exp_lo});
      check($sformatf("v%0d_hi_addr", i), {14'd0, addr_log[6]}, {14'd0, vecs[i].exp_lo + 18'd1});
      check($sformatf("v%0d_readData", i), readData5, vecs[i].exp_rd);
      check($sformatf("v%0d_we_cycles", i), we_low, vecs[i].we ? 32'd10 : 32'd0);
      if (vecs[i].we) begin
        check($sformatf("v%0d_mem_lo", i), {16'd0, mem5[vecs[i].exp_lo]}, {16'd0, vecs[i].wdata[15:0]});
        check($sformatf("v%0d_mem_hi", i), {16'd0, mem5[vecs[i].exp_lo + 18'd1]}, {16'd0, vecs[i].wdata[31:16]});
      end
    end

    // Back-to-back store then load on the W=1 instance.
    @(posedge clk); #1;
    run(1'b1, 1'b0, 1'b1, 32'd1040, 32'hCAFE1234, low, we_low);
    check("b2b_st_low", low, 32'd3);
    check("b2b_st_we_cycles", we_low, 32'd2);
    check("b2b_st_lo_addr", {14'd0, addr_log[1]}, 32'd8);
    check("b2b_st_hi_addr", {14'd0, addr_log[2]}, 32'd9);
    @(posedge clk); #1;
    run(1'b1, 1'b1, 1'b0, 32'd1040, 32'h0, low, we_low);
    check("b2b_ld_low", low, 32'd3);
    check("b2b_ld_readData", readData1, 32'hCAFE1234);
    check("b2b_mem_lo", {16'd0, mem1[18'd8]}, 32'h00001234);
    check("b2b_mem_hi", {16'd0, mem1[18'd9]}, 32'h0000CAFE);

    // Reset in the middle of the HI half of a load.
    repeat (16) @(posedge clk);
    #1;
    memREn = 1'b1; address = 32'd1032;
    @(posedge clk); #1;
    memREn = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("mid_lo_captured", readData5, 32'h0BAD5678);
    check("mid_ready_low", {31'd0, ready5}, 32'd0);
    rst = 1'b0;
    #1;
    check("mid_rst_readData", readData5, 32'd0);
    check("mid_rst_ready", {31'd0, ready5}, 32'd1);
    check("mid_rst_weN", {31'd0, sramWeN5}, 32'd1);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", {31'd0, ready5}, 32'd1);
    check("post_rst_dqoe", {31'd0, sramDqOe5}, 32'd0);
    check("post_rst_readData", readData5, 32'd0);

`ifdef MEM_STAGE_RANGE_CHECK_EN
    // Load below the window base is rejected in a single cycle.
    memREn = 1'b1; address = 32'd1000;
    #1;
    check("rng_err", {31'd0, err5}, 32'd1);
    check("rng_ready", {31'd0, ready5}, 32'd1);
    check("rng_weN", {31'd0, sramWeN5}, 32'd1);
    @(posedge clk); #1;
    memREn = 1'b0;
    #1;
    check("rng_err_clear", {31'd0, err5}, 32'd0);
    check("rng_readData", readData5, 32'd0);
    check("rng_dqoe", {31'd0, sramDqOe5}, 32'd0);
    check("rng_weN_after", {31'd0, sramWeN5}, 32'd1);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
